// File: rtl/iopmp_pkg.sv
// Shared IOPMP types: TL-UL channel payloads, error-reporting config and the
// deny-responder queue entry.
package iopmp_pkg;

    localparam int unsigned SourceWidth     = 8;
    localparam int unsigned TlAddrW         = 32;
    localparam int unsigned TlDataW         = 32;
    localparam int unsigned TlSizeW         = 2;
    localparam int unsigned TlMaskW         = TlDataW / 8;
    localparam int unsigned TlUserW         = 4;
    localparam int unsigned IOPMP_ERR_CNT_W = 8;

    // TL-UL A-channel opcodes
    localparam logic [2:0] TL_PUT_FULL_DATA    = 3'h0;
    localparam logic [2:0] TL_PUT_PARTIAL_DATA = 3'h1;
    localparam logic [2:0] TL_GET              = 3'h4;

    // TL-UL D-channel opcodes
    localparam logic [2:0] TL_ACCESS_ACK      = 3'h0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'h1;

    typedef enum logic [1:0] {
        IOPMP_ACC_NONE  = 2'd0,
        IOPMP_ACC_READ  = 2'd1,
        IOPMP_ACC_WRITE = 2'd2,
        IOPMP_ACC_EXEC  = 2'd3
    } iopmp_req_e;

    typedef struct packed {
        logic rwe;
        logic rre;
    } err_cfg;

    typedef struct packed {
        logic                   a_valid;
        logic [2:0]             a_opcode;
        logic [2:0]             a_param;
        logic [TlSizeW-1:0]     a_size;
        logic [SourceWidth-1:0] a_source;
        logic [TlAddrW-1:0]     a_address;
        logic [TlMaskW-1:0]     a_mask;
        logic [TlDataW-1:0]     a_data;
        logic [TlUserW-1:0]     a_user;
        logic                   d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                   d_valid;
        logic [2:0]             d_opcode;
        logic [2:0]             d_param;
        logic [TlSizeW-1:0]     d_size;
        logic [SourceWidth-1:0] d_source;
        logic                   d_sink;
        logic [TlDataW-1:0]     d_data;
        logic [TlUserW-1:0]     d_user;
        logic                   d_error;
        logic                   a_ready;
    } tl_d2h_t;

    typedef struct packed {
        logic [2:0]             kind;
        logic [TlSizeW-1:0]     size;
        logic [SourceWidth-1:0] source;
        logic                   err;
    } deny_rsp_entry_t;

endpackage

// File: rtl/iopmp_deny_rsp_fifo.sv
// Response queue for the deny responder: head entry, full and empty are all
// held in flops so the D channel is driven straight from registers.
module iopmp_deny_rsp_fifo #(
    parameter int unsigned Depth = 2,
    parameter type         T     = logic [0:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  T     i_wdata,
    input  logic i_pop,
    output T     o_rdata,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    T                r_mem [Depth];
    T                r_head;
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_cnt;
    logic            r_full;
    logic            r_empty;

    logic            w_push;
    logic            w_pop;
    logic [PtrW-1:0] w_rptr_nxt;
    logic [CntW-1:0] w_cnt_nxt;
    logic [CntW-1:0] w_cnt_after_pop;
    T                w_head_nxt;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && !r_empty;

    // Next head: bypass the write when the queue drains to it, zero when empty.
    always_comb begin
        w_rptr_nxt      = w_pop ? next_ptr(r_rptr) : r_rptr;
        w_cnt_after_pop = r_cnt - CntW'(w_pop);
        w_cnt_nxt       = w_cnt_after_pop + CntW'(w_push);
        w_head_nxt      = r_head;
        if (w_cnt_nxt == '0) begin
            w_head_nxt = '0;
        end else if (w_push && (w_cnt_after_pop == '0)) begin
            w_head_nxt = i_wdata;
        end else if (w_pop) begin
            w_head_nxt = r_mem[w_rptr_nxt];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem   <= '{default: '0};
            r_head  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= next_ptr(r_wptr);
            end
            r_rptr  <= w_rptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_head  <= w_head_nxt;
            r_full  <= (w_cnt_nxt == CntW'(Depth));
            r_empty <= (w_cnt_nxt == '0);
        end
    end

    assign o_rdata = r_head;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/iopmp_deny_rsp_tlul.sv
// TL-UL terminator for IOPMP-denied requests: error or suppressed responses,
// plus first-violation capture when IOPMP_ERR_CAPTURE_EN is defined.
module iopmp_deny_rsp_tlul
    import iopmp_pkg::*;
#(
    parameter int unsigned       RspDepth = 2,
    parameter logic [TlDataW-1:0] ReadFill = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  tl_h2d_t                    tl_i,
    output tl_d2h_t                    tl_o,
    input  err_cfg                     ERR_CFG,
    output logic                       err_valid_o,
    output logic [TlAddrW-1:0]         err_addr_o,
    output iopmp_req_e                 err_type_o,
    output logic [SourceWidth-1:0]     err_rrid_o,
    output logic [IOPMP_ERR_CNT_W-1:0] err_cnt_o,
    input  logic                       err_clear_i
);

    deny_rsp_entry_t w_entry;
    deny_rsp_entry_t w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_accept;
    logic            w_is_write;
    logic            w_unused;

    assign w_accept = tl_i.a_valid && !w_full;

    // Opcode decode; ERR_CFG is frozen into the entry at acceptance.
    always_comb begin
        w_entry        = '0;
        w_entry.size   = tl_i.a_size;
        w_entry.source = tl_i.a_source;
        w_is_write     = 1'b0;
        case (tl_i.a_opcode)
            TL_GET: begin
                w_entry.kind = TL_ACCESS_ACK_DATA;
                w_entry.err  = !ERR_CFG.rre;
            end
            TL_PUT_FULL_DATA, TL_PUT_PARTIAL_DATA: begin
                w_entry.kind = TL_ACCESS_ACK;
                w_entry.err  = !ERR_CFG.rwe;
                w_is_write   = 1'b1;
            end
            default: begin
                w_entry.kind = TL_ACCESS_ACK;
                w_entry.err  = 1'b1;
            end
        endcase
    end

    iopmp_deny_rsp_fifo #(
        .Depth (RspDepth),
        .T     (deny_rsp_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_wdata (w_entry),
        .i_pop   (tl_i.d_ready),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign tl_o.a_ready  = !w_full;
    assign tl_o.d_valid  = !w_empty;
    assign tl_o.d_opcode = w_head.kind;
    assign tl_o.d_param  = '0;
    assign tl_o.d_size   = w_head.size;
    assign tl_o.d_source = w_head.source;
    assign tl_o.d_sink   = 1'b0;
    assign tl_o.d_user   = '0;
    assign tl_o.d_error  = w_head.err;
    assign tl_o.d_data   = ((w_head.kind == TL_ACCESS_ACK_DATA) && !w_head.err) ? ReadFill : '0;

`ifdef IOPMP_ERR_CAPTURE_EN
    logic                       r_err_valid;
    logic [TlAddrW-1:0]         r_err_addr;
    iopmp_req_e                 r_err_type;
    logic [SourceWidth-1:0]     r_err_rrid;
    logic [IOPMP_ERR_CNT_W-1:0] r_err_cnt;

    // First violation is recorded; later ones only bump the saturating count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
            r_err_type  <= IOPMP_ACC_READ;
            r_err_rrid  <= '0;
            r_err_cnt   <= '0;
        end else if (w_accept) begin
            if (err_clear_i || !r_err_valid) begin
                r_err_valid <= 1'b1;
                r_err_addr  <= tl_i.a_address;
                r_err_type  <= w_is_write ? IOPMP_ACC_WRITE : IOPMP_ACC_READ;
                r_err_rrid  <= tl_i.a_source;
                r_err_cnt   <= IOPMP_ERR_CNT_W'(1);
            end else if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + IOPMP_ERR_CNT_W'(1);
            end
        end else if (err_clear_i) begin
            r_err_valid <= 1'b0;
            r_err_cnt   <= '0;
        end
    end

    assign err_valid_o = r_err_valid;
    assign err_addr_o  = r_err_addr;
    assign err_type_o  = r_err_type;
    assign err_rrid_o  = r_err_rrid;
    assign err_cnt_o   = r_err_cnt;
    assign w_unused    = ^{tl_i.a_param, tl_i.a_mask, tl_i.a_data, tl_i.a_user};
`else
    assign err_valid_o = 1'b0;
    assign err_addr_o  = '0;
    assign err_type_o  = IOPMP_ACC_READ;
    assign err_rrid_o  = '0;
    assign err_cnt_o   = '0;
    assign w_unused    = ^{tl_i.a_param, tl_i.a_mask, tl_i.a_data, tl_i.a_user,
                           tl_i.a_address, w_is_write, err_clear_i};
`endif

endmodule

// File: tb/tb_iopmp_deny_rsp_tlul.sv
// Directed self-checking bench for iopmp_deny_rsp_tlul (RspDepth 2, ReadFill DEADBEEF).
module tb_iopmp_deny_rsp_tlul;
    import iopmp_pkg::*;

    logic                       clk;
    logic                       rst;
    tl_h2d_t                    tl_i;
    tl_d2h_t                    tl_o;
    err_cfg                     cfg;
    logic                       err_valid;
    logic [31:0]                err_addr;
    iopmp_req_e                 err_type;
    logic [SourceWidth-1:0]     err_rrid;
    logic [IOPMP_ERR_CNT_W-1:0] err_cnt;
    logic                       err_clear;

    int unsigned errors = 0;
    int unsigned checks = 0;

    iopmp_deny_rsp_tlul #(
        .RspDepth (2),
        .ReadFill (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tl_i        (tl_i),
        .tl_o        (tl_o),
        .ERR_CFG     (cfg),
        .err_valid_o (err_valid),
        .err_addr_o  (err_addr),
        .err_type_o  (err_type),
        .err_rrid_o  (err_rrid),
        .err_cnt_o   (err_cnt),
        .err_clear_i (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Error-record check; without the capture feature the outputs are tied off.
    task automatic chk_err(input string tag, input logic v, input logic [31:0] a,
                           input iopmp_req_e t, input logic [7:0] r, input logic [7:0] c);
`ifdef IOPMP_ERR_CAPTURE_EN
        chk({tag, ".valid"}, 32'(err_valid), 32'(v));
        chk({tag, ".addr"},  err_addr, a);
        chk({tag, ".type"},  32'(err_type), 32'(t));
        chk({tag, ".rrid"},  32'(err_rrid), 32'(r));
        chk({tag, ".cnt"},   32'(err_cnt), 32'(c));
`else
        chk({tag, ".valid"}, 32'(err_valid), 32'(1'b0 & v));
        chk({tag, ".addr"},  err_addr, 32'h0 & a);
        chk({tag, ".type"},  32'(err_type), 32'(IOPMP_ACC_READ) | (32'(t) & 32'h0));
        chk({tag, ".rrid"},  32'(err_rrid), 32'(8'h0 & r));
        chk({tag, ".cnt"},   32'(err_cnt), 32'(8'h0 & c));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [31:0] addr,
                           input logic [7:0] src, input logic [1:0] size);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_address = addr;
        tl_i.a_source  = src;
        tl_i.a_size    = size;
    endtask

    initial begin
        rst       = 1'b1;
        tl_i      = '0;
        cfg       = '0;
        err_clear = 1'b0;
        #12;
        chk("rst.a_ready",  32'(tl_o.a_ready), 32'd1);
        chk("rst.d_valid",  32'(tl_o.d_valid), 32'd0);
        chk("rst.d_opcode", 32'(tl_o.d_opcode), 32'd0);
        chk("rst.d_data",   tl_o.d_data, 32'd0);
        chk("rst.d_error",  32'(tl_o.d_error), 32'd0);
        chk_err("rst.err", 1'b0, 32'h0, IOPMP_ACC_READ, 8'd0, 8'd0);
        step();
        rst = 1'b0;
        step();

        // Denied Get with read errors enabled
        tl_i.d_ready = 1'b1;
        drive_a(TL_GET, 32'h8000_0010, 8'd3, 2'd2);
        step();
        tl_i.a_valid = 1'b0;
        chk("get.d_valid",  32'(tl_o.d_valid), 32'd1);
        chk("get.d_opcode", 32'(tl_o.d_opcode), 32'(TL_ACCESS_ACK_DATA));
        chk("get.d_error",  32'(tl_o.d_error), 32'd1);
        chk("get.d_source", 32'(tl_o.d_source), 32'd3);
        chk("get.d_data",   tl_o.d_data, 32'd0);
        chk_err("get.err", 1'b1, 32'h8000_0010, IOPMP_ACC_READ, 8'd3, 8'd1);
        step();
        chk("get.drain", 32'(tl_o.d_valid), 32'd0);

        // Suppressed write
        cfg.rwe = 1'b1;
        drive_a(TL_PUT_FULL_DATA, 32'h8000_0020, 8'd5, 2'd1);
        step();
        tl_i.a_valid = 1'b0;
        chk("put.d_opcode", 32'(tl_o.d_opcode), 32'(TL_ACCESS_ACK));
        chk("put.d_error",  32'(tl_o.d_error), 32'd0);
        chk("put.d_data",   tl_o.d_data, 32'd0);
        chk("put.d_source", 32'(tl_o.d_source), 32'd5);
        chk_err("put.err", 1'b1, 32'h8000_0010, IOPMP_ACC_READ, 8'd3, 8'd2);
        step();

        // Suppressed read returns the fill pattern
        cfg.rre = 1'b1;
        drive_a(TL_GET, 32'h8000_0030, 8'd6, 2'd2);
        step();
        tl_i.a_valid = 1'b0;
        chk("sget.d_opcode", 32'(tl_o.d_opcode), 32'(TL_ACCESS_ACK_DATA));
        chk("sget.d_error",  32'(tl_o.d_error), 32'd0);
        chk("sget.d_data",   tl_o.d_data, 32'hDEAD_BEEF);
        chk("sget.d_size",   32'(tl_o.d_size), 32'd2);
        step();

        // Unsupported opcode always errors
        drive_a(3'h5, 32'h8000_0040, 8'd9, 2'd0);
        step();
        tl_i.a_valid = 1'b0;
        chk("intent.d_opcode", 32'(tl_o.d_opcode), 32'(TL_ACCESS_ACK));
        chk("intent.d_error",  32'(tl_o.d_error), 32'd1);
        chk("intent.d_data",   tl_o.d_data, 32'd0);
        step();

        // Backpressure: fill both slots, hold, then drain in order
        cfg.rre      = 1'b0;
        tl_i.d_ready = 1'b0;
        drive_a(TL_GET, 32'h0, 8'd10, 2'd2);
        step();
        chk("bp.a_ready1", 32'(tl_o.a_ready), 32'd1);
        tl_i.a_source = 8'd11;
        step();
        chk("bp.a_ready2", 32'(tl_o.a_ready), 32'd0);
        chk("bp.head0",    32'(tl_o.d_source), 32'd10);
        tl_i.a_source = 8'd12;
        step();
        chk("bp.full_hold", 32'(tl_o.a_ready), 32'd0);
        chk("bp.head_hold", 32'(tl_o.d_source), 32'd10);
        chk("bp.err_hold",  32'(tl_o.d_error), 32'd1);
        cfg.rre      = 1'b1;
        tl_i.d_ready = 1'b1;
        step();
        chk("bp.head1",   32'(tl_o.d_source), 32'd11);
        chk("bp.frozen",  32'(tl_o.d_error), 32'd1);
        chk("bp.reopen",  32'(tl_o.a_ready), 32'd1);
        step();
        tl_i.a_valid = 1'b0;
        chk("bp.head2",   32'(tl_o.d_source), 32'd12);
        chk("bp.newcfg",  32'(tl_o.d_error), 32'd0);
        chk("bp.fill",    tl_o.d_data, 32'hDEAD_BEEF);
        step();
        chk("bp.empty",   32'(tl_o.d_valid), 32'd0);
        chk("bp.a_ready", 32'(tl_o.a_ready), 32'd1);

        // Clear without acceptance
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk_err("clr.err", 1'b0, err_addr, err_type, err_rrid, 8'd0);

        // 300 back-to-back violations saturate the count
        drive_a(TL_GET, 32'h0000_1000, 8'd1, 2'd2);
        step();
        for (int i = 1; i < 300; i++) begin
            tl_i.a_address = 32'h0000_2000 + 32'(i);
            step();
        end
        tl_i.a_valid = 1'b0;
        chk("sat.a_ready", 32'(tl_o.a_ready), 32'd1);
        chk_err("sat.err", 1'b1, 32'h0000_1000, IOPMP_ACC_READ, 8'd1, 8'hFF);
        step();

        // Clear coinciding with a new Put records the new beat
        err_clear = 1'b1;
        drive_a(TL_PUT_PARTIAL_DATA, 32'h0000_3000, 8'd7, 2'd2);
        step();
        err_clear    = 1'b0;
        tl_i.a_valid = 1'b0;
        chk_err("clrput.err", 1'b1, 32'h0000_3000, IOPMP_ACC_WRITE, 8'd7, 8'd1);
        step();

        // Async reset flushes queued responses
        tl_i.d_ready = 1'b0;
        drive_a(TL_GET, 32'h0000_4000, 8'd20, 2'd2);
        step();
        tl_i.a_source = 8'd21;
        step();
        tl_i.a_valid = 1'b0;
        chk("flush.pre", 32'(tl_o.d_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("flush.d_valid", 32'(tl_o.d_valid), 32'd0);
        chk("flush.a_ready", 32'(tl_o.a_ready), 32'd1);
        chk_err("flush.err", 1'b0, 32'h0, IOPMP_ACC_READ, 8'd0, 8'd0);
        step();
        rst          = 1'b0;
        tl_i.d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush.quiet", 32'(tl_o.d_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
